// File: rtl/wired_pkg_intake_pkg.sv
// Shared types for the backend package intake: instruction slot payload, frontend redirect
// record and ROB index type.
package wired_pkg_intake_pkg;

  localparam int unsigned DEF_ROB_DEPTH = 32;
  localparam int unsigned DEF_ROB_IDX_W = $clog2(DEF_ROB_DEPTH);

  typedef logic [DEF_ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  fu_sel;
    logic        need_rd;
  } pipeline_ctrl_pack_t;

  typedef struct packed {
    logic        redirect;
    logic        tid;
    logic [31:0] pc;
    logic [31:0] target;
  } bpu_correct_t;

  localparam int unsigned PACK_W = $bits(pipeline_ctrl_pack_t);
  localparam int unsigned BPU_W  = $bits(bpu_correct_t);

  function automatic logic [1:0] slot_count(input logic [1:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

endpackage

// File: rtl/wired_pkg_intake_rob_credit.sv
// ROB credit counter and tail pointer; produces the per-slot ROB indices for the held package.
module wired_pkg_intake_rob_credit
  import wired_pkg_intake_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int unsigned ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_issue,
  input  logic [1:0]                i_mask,
  input  logic [1:0]                i_commit_cnt,
  input  logic                      i_flush,
  output logic [ROB_IDX_W:0]        o_credits,
  output logic [1:0][ROB_IDX_W-1:0] o_rob_idx
);

  localparam int unsigned CW = ROB_IDX_W + 1;

  logic [CW-1:0]        r_credits;
  logic [CW-1:0]        w_credits_next;
  logic [ROB_IDX_W-1:0] r_tail;
  logic [ROB_IDX_W-1:0] w_tail_next;
  logic [1:0]           w_nslot;

  assign w_nslot = slot_count(i_mask);

  always_comb begin
    w_credits_next = r_credits - (i_issue ? CW'(w_nslot) : CW'(0)) + CW'(i_commit_cnt);
    w_tail_next    = i_issue ? r_tail + ROB_IDX_W'(w_nslot) : r_tail;
    if (i_flush) begin
      w_credits_next = CW'(ROB_DEPTH);
      w_tail_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CW'(ROB_DEPTH);
      r_tail    <= '0;
    end else begin
      r_credits <= w_credits_next;
      r_tail    <= w_tail_next;
    end
  end

  assign o_credits    = r_credits;
  assign o_rob_idx[0] = r_tail;
  assign o_rob_idx[1] = r_tail + ROB_IDX_W'(i_mask[0]);

  // More retirements than issued entries would mean the ROB and this counter disagree.
  a_credit_bound: assert property (@(posedge clk) disable iff (rst) r_credits <= CW'(ROB_DEPTH));

endmodule

// File: rtl/wired_pkg_intake.sv
// Backend intake of 2-wide frontend packages: one-entry hold register, ROB credit gating and
// frontend redirect/tid generation. Define WIRED_INTAKE_PERF_EN for stall/empty counters.
module wired_pkg_intake
  import wired_pkg_intake_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int unsigned ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pkg_valid_i,
  output logic                      pkg_ready_o,
  input  logic [1:0]                pkg_mask_i,
  input  logic [1:0][PACK_W-1:0]    pkg_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [1:0]                r_mask_o,
  output logic [1:0][PACK_W-1:0]    r_pkg_o,
  output logic [1:0][ROB_IDX_W-1:0] r_rob_idx_o,
  input  logic [1:0]                commit_cnt_i,
  input  logic                      redirect_valid_i,
  input  logic [BPU_W-1:0]          redirect_i,
  output logic [BPU_W-1:0]          bpu_correct_o
`ifdef WIRED_INTAKE_PERF_EN
  ,
  output logic [31:0]               perf_credit_stall_o,
  output logic [31:0]               perf_empty_o
`endif
);

  localparam int unsigned CW = ROB_IDX_W + 1;

  logic                   r_hold_valid;
  logic [1:0]             r_hold_mask;
  logic [1:0][PACK_W-1:0] r_hold_pkg;
  logic                   r_tid;
  bpu_correct_t           r_bpu;
  bpu_correct_t           w_bpu_next;
  logic [1:0]             w_nslot;
  logic [CW-1:0]          w_credits;
  logic                   w_credit_ok;
  logic                   w_valid;
  logic                   w_issue;
  logic                   w_ready;
  logic                   w_accept;

  assign w_nslot     = slot_count(r_hold_mask);
  assign w_credit_ok = w_credits >= CW'(w_nslot);
  // An empty-mask package is never offered to rename; it just falls out of the hold register.
  assign w_valid     = r_hold_valid && (w_nslot != 2'd0) && w_credit_ok;
  assign w_issue     = w_valid && r_ready_i;
  assign w_ready     = !redirect_valid_i && (!r_hold_valid || w_issue);
  assign w_accept    = pkg_valid_i && w_ready;

  wired_pkg_intake_rob_credit #(
    .ROB_DEPTH (ROB_DEPTH),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_rob_credit (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (w_issue),
    .i_mask       (r_hold_mask),
    .i_commit_cnt (commit_cnt_i),
    .i_flush      (redirect_valid_i),
    .o_credits    (w_credits),
    .o_rob_idx    (r_rob_idx_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_mask  <= '0;
      r_hold_pkg   <= '0;
    end else if (redirect_valid_i) begin
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_mask  <= pkg_mask_i;
      r_hold_pkg   <= pkg_i;
    end else if (r_hold_valid && (w_issue || w_nslot == 2'd0)) begin
      r_hold_valid <= 1'b0;
    end
  end

  // The frontend drops any package whose tid differs from the one carried by the last redirect.
  always_comb begin
    w_bpu_next = '0;
    if (redirect_valid_i) begin
      w_bpu_next          = bpu_correct_t'(redirect_i);
      w_bpu_next.tid      = ~r_tid;
      w_bpu_next.redirect = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tid <= 1'b0;
      r_bpu <= '0;
    end else begin
      r_bpu <= w_bpu_next;
      if (redirect_valid_i) begin
        r_tid <= ~r_tid;
      end
    end
  end

  assign pkg_ready_o   = w_ready;
  assign r_valid_o     = w_valid;
  assign r_mask_o      = r_hold_mask;
  assign r_pkg_o       = r_hold_pkg;
  assign bpu_correct_o = r_bpu;

`ifdef WIRED_INTAKE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_empty <= '0;
    end else begin
      if (r_hold_valid && !w_credit_ok && r_perf_stall != '1) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (!r_hold_valid && r_perf_empty != '1) begin
        r_perf_empty <= r_perf_empty + 32'd1;
      end
    end
  end

  assign perf_credit_stall_o = r_perf_stall;
  assign perf_empty_o        = r_perf_empty;
`else
  // Counters absent in the default build.
`endif

endmodule
